mix_columns: RTL and testbench

- AES MixColumns stage (FIPS-197 §5.1.3) for one 128-bit state per transfer.
- Each 32-bit column is multiplied by the fixed GF(2^8) matrix [02 03 01 01; 01 02 03 01; 01 01 02 03; 03 01 01 02].
- Sits in the AES round datapath after ShiftRows and before AddRoundKey.
- Output is registered: one result per clock, latency 1.

---
 rtl/mix_columns.sv | 109 ++++++++++
 tb/tb_mix_columns.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mix_columns.sv
// AES MixColumns stage: four parallel GF(2^8) column units feeding one output register (latency 1).
// Optional build macro MIX_COLUMNS_INV_EN adds i_inv to select InvMixColumns per transfer.
module mix_columns (
    input  logic         clk,
    input  logic         n_rst,
`ifdef MIX_COLUMNS_INV_EN
    input  logic         i_inv,
`endif
    input  logic         i_valid,
    input  logic [127:0] i_data,
    output logic         o_valid,
    output logic [127:0] o_data
);

    function automatic logic [7:0] xtime(input logic [7:0] x);
        xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] x);
        mul3 = xtime(x) ^ x;
    endfunction

    function automatic logic [31:0] mix_col_fwd(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ mul3(a1)  ^ a2        ^ a3;
        b1 = a0        ^ xtime(a1) ^ mul3(a2)  ^ a3;
        b2 = a0        ^ a1        ^ xtime(a2) ^ mul3(a3);
        b3 = mul3(a0)  ^ a1        ^ a2        ^ xtime(a3);
        mix_col_fwd = {b0, b1, b2, b3};
    endfunction

`ifdef MIX_COLUMNS_INV_EN
    // Each byte's x2/x4/x8 chain is computed once and shared by the 9/b/d/e products.
    function automatic logic [31:0] mix_col_inv(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        a[0] = col[31:24];
        a[1] = col[23:16];
        a[2] = col[15:8];
        a[3] = col[7:0];
        for (int k = 0; k < 4; k++) begin
            x2[k] = xtime(a[k]);
            x4[k] = xtime(x2[k]);
            x8[k] = xtime(x4[k]);
            m9[k] = x8[k] ^ a[k];
            mb[k] = x8[k] ^ x2[k] ^ a[k];
            md[k] = x8[k] ^ x4[k] ^ a[k];
            me[k] = x8[k] ^ x4[k] ^ x2[k];
        end
        mix_col_inv = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                       m9[0] ^ me[1] ^ mb[2] ^ md[3],
                       md[0] ^ m9[1] ^ me[2] ^ mb[3],
                       mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction
`endif

    logic [127:0] mixed;

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [31:0] col_in;
        logic [31:0] col_fwd;
        assign col_in  = i_data[127-32*c -: 32];
        assign col_fwd = mix_col_fwd(col_in);
`ifdef MIX_COLUMNS_INV_EN
        logic [31:0] col_inv;
        assign col_inv = mix_col_inv(col_in);
        assign mixed[127-32*c -: 32] = i_inv ? col_inv : col_fwd;
`else
        assign mixed[127-32*c -: 32] = col_fwd;
`endif
    end

    logic         o_valid_q, o_valid_d;
    logic [127:0] o_data_q,  o_data_d;

    // Hold on idle cycles so a don't-care i_data never reaches the output.
    always_comb begin
        o_valid_d = i_valid;
        o_data_d  = o_data_q;
        if (i_valid) begin
            o_data_d = mixed;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            o_valid_q <= 1'b0;
            o_data_q  <= 128'h0;
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;

endmodule

// File: tb/tb_mix_columns.sv
// Scoreboard bench for mix_columns: expectations queued at drive time, popped one cycle later.
module tb_mix_columns;

    logic         clk;
    logic         n_rst;
    logic         i_valid;
    logic [127:0] i_data;
    logic         i_inv;
    logic         o_valid;
    logic [127:0] o_data;

    mix_columns dut (
        .clk     (clk),
        .n_rst   (n_rst),
`ifdef MIX_COLUMNS_INV_EN
        .i_inv   (i_inv),
`endif
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_data  (o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         v;
        logic [127:0] d;
    } sb_t;

    sb_t          sb_q[$];
    logic [127:0] last_exp;
    int           n_checks;
    int           n_fail;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Generic shift-and-add multiply; independent of any xtime decomposition.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] blk, input bit inv);
        logic [7:0]   row0 [4];
        logic [7:0]   acc;
        logic [127:0] res;
        if (inv) begin
            row0[0] = 8'h0e; row0[1] = 8'h0b; row0[2] = 8'h0d; row0[3] = 8'h09;
        end else begin
            row0[0] = 8'h02; row0[1] = 8'h03; row0[2] = 8'h01; row0[3] = 8'h01;
        end
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gmul(row0[(k - r + 4) % 4], blk[127 - 8*(4*c + k) -: 8]);
                end
                res[127 - 8*(4*c + r) -: 8] = acc;
            end
        end
        return res;
    endfunction

    task automatic drive(input logic v, input logic [127:0] d, input logic inv, input logic [127:0] exp);
        sb_t e;
        @(negedge clk);
        i_valid = v;
        i_data  = d;
        i_inv   = inv;
        if (v) last_exp = exp;
        e.v = v;
        e.d = last_exp;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, '0);
    endtask

    // Every driven cycle has a queue entry, so each post-edge sample pops exactly one.
    always @(posedge clk) begin
        sb_t e;
        #1;
        if (n_rst) begin
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("o_valid", {127'b0, o_valid}, {127'b0, e.v});
                check("o_data", o_data, e.d);
            end else begin
                check("o_valid_idle", {127'b0, o_valid}, 128'h0);
                check("o_data_idle", o_data, last_exp);
            end
        end
    end

    initial begin
        logic [127:0] x;
        logic [127:0] y;
        n_checks = 0;
        n_fail   = 0;
        last_exp = '0;
        n_rst    = 1'b0;
        i_valid  = 1'b0;
        i_data   = '0;
        i_inv    = 1'b0;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            i_valid = 1'($urandom);
            i_data  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            check("rst_valid", {127'b0, o_valid}, 128'h0);
            check("rst_data", o_data, 128'h0);
        end
        @(negedge clk);
        i_valid = 1'b0;
        n_rst   = 1'b1;

        drive(1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c);
        drive(1'b1, 128'hdb135345f20a225c01010101c6c6c6c6, 1'b0, 128'h8e4da1bc9fdc589d01010101c6c6c6c6);
        drive(1'b1, 128'hd4d4d4d52d26314c00000000ffffffff, 1'b0, 128'hd5d5d7d64d7ebdf800000000ffffffff);
        idle(2);

        // Async reset mid-cycle: the in-flight block is popped first, then reset must clear at once.
        drive(1'b1, 128'h00112233445566778899aabbccddeeff, 1'b0, model(128'h00112233445566778899aabbccddeeff, 1'b0));
        @(posedge clk);
        #3;
        n_rst   = 1'b0;
        i_valid = 1'b0;
        #1;
        check("async_rst_valid", {127'b0, o_valid}, 128'h0);
        check("async_rst_data", o_data, 128'h0);
        sb_q.delete();
        last_exp = '0;
        @(negedge clk);
        n_rst = 1'b1;
        idle(1);

        for (int i = 0; i < 500; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            drive(1'b1, x, 1'b0, model(x, 1'b0));
        end
        idle(3);

`ifdef MIX_COLUMNS_INV_EN
        drive(1'b1, 128'h046681e5e0cb199a48f8d37a2806264c, 1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        for (int i = 0; i < 20; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            y = model(x, 1'b0);
            drive(1'b1, x, 1'b0, y);
            drive(1'b1, y, 1'b1, x);
        end
        idle(2);
`endif

        @(posedge clk);
        #2;
        check("sb_empty", 128'(sb_q.size()), 128'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
